// File: rtl/mm_pkg.sv
// Shared constants, loader state encoding and RAM layout helpers for the
// Jacobi matrix-multiply datapath (loader and multiplier both import this).
package mm_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int N_WIDTH    = 3;
  localparam int MAX_N      = 7;

  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_LOAD_A_ENC    = 3'd1;
  localparam logic [2:0] ST_LOAD_B_ENC    = 3'd2;
  localparam logic [2:0] ST_GO_ENC        = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_LOAD_A    = ST_LOAD_A_ENC,
    ST_LOAD_B    = ST_LOAD_B_ENC,
    ST_GO        = ST_GO_ENC,
    ST_WAIT_DONE = ST_WAIT_DONE_ENC
  } loader_state_t;

  // RAM layout: A at word 0, B right after A, result R right after B.
  localparam logic [ADDR_WIDTH-1:0] BASE_A = '0;

  function automatic logic [ADDR_WIDTH-1:0] base_b(input logic [N_WIDTH-1:0] n);
    return ADDR_WIDTH'(n) * ADDR_WIDTH'(n);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] base_r(input logic [N_WIDTH-1:0] n);
    return base_b(n) << 1;
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Byte-stream loader: takes header N, then A and B row-major, writes them to
// the multiplier's RAM, pulses go and waits for the multiplier to finish.
module matrix_loader #(
  parameter int DATA_WIDTH = mm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mm_pkg::ADDR_WIDTH,
  parameter int N_WIDTH    = mm_pkg::N_WIDTH,
  parameter int MAX_N      = mm_pkg::MAX_N
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  go,
  output logic [DATA_WIDTH-1:0] n_out,
  input  logic                  mm_done,
  output logic                  busy,
  output logic                  err
);
  import mm_pkg::*;

  localparam int NNW = 2 * N_WIDTH;

  loader_state_t         r_state, w_state_nxt;
  logic [NNW-1:0]        r_cnt, w_cnt_nxt;
  logic [NNW-1:0]        r_nn, w_nn_nxt;
  logic [DATA_WIDTH-1:0] r_n, w_n_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_data, w_mem_data_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic                  r_go, w_go_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_xfer, w_hdr_ok, w_last;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign busy     = (r_state != ST_IDLE);
  assign w_xfer   = in_valid && in_ready;
  // Compare the full byte so an out-of-range header cannot alias into 1..MAX_N.
  assign w_hdr_ok = (in_data != '0) && (in_data <= DATA_WIDTH'(MAX_N));
  assign w_last   = (r_cnt == r_nn - NNW'(1));

  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_we   = r_mem_we;
  assign go       = r_go;
  assign err      = r_err;
  assign n_out    = r_n;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can form.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_nn_nxt       = r_nn;
    w_n_nxt        = r_n;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_mem_we_nxt   = 1'b0;
    w_go_nxt       = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_hdr_ok) begin
            w_n_nxt     = in_data;
            w_nn_nxt    = NNW'(base_b(in_data[N_WIDTH-1:0]));
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LOAD_A;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (w_xfer) begin
          w_mem_addr_nxt = (r_state == ST_LOAD_A) ? ADDR_WIDTH'(BASE_A) + ADDR_WIDTH'(r_cnt)
                                                  : ADDR_WIDTH'(r_nn) + ADDR_WIDTH'(r_cnt);
          w_mem_data_nxt = in_data;
          w_mem_we_nxt   = 1'b1;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == ST_LOAD_A) ? ST_LOAD_B : ST_GO;
          end else begin
            w_cnt_nxt = r_cnt + NNW'(1);
          end
        end
      end
      ST_GO: begin
        // The last B word lands on this edge, so go follows it strictly.
        w_go_nxt    = 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (mm_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_nn       <= '0;
      r_n        <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_go       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_nn       <= w_nn_nxt;
      r_n        <= w_n_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_data <= w_mem_data_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_go       <= w_go_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
